// File: rtl/md_unit.sv
// md_unit: multi-cycle multiply/divide unit with HI/LO registers, placed beside the E-stage ALU.
// Operands are captured at start; HI/LO are written when the cycle count expires.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    // Low 64 bits of the product; sign-extending the operands makes this the signed product.
    function automatic logic [63:0] mul64(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic [63:0] xe;
        logic [63:0] ye;
        xe = {(sgn ? {32{x[31]}} : 32'h0000_0000), x};
        ye = {(sgn ? {32{y[31]}} : 32'h0000_0000), y};
        return xe * ye;
    endfunction

    // Returns {remainder, quotient}; signed case divides magnitudes so 0x80000000 / -1 wraps cleanly.
    function automatic logic [63:0] div64(input logic [31:0] x, input logic [31:0] y, input logic sgn);
        logic        xn;
        logic        yn;
        logic [31:0] xm;
        logic [31:0] ym;
        logic [31:0] q;
        logic [31:0] r;
        xn = sgn & x[31];
        yn = sgn & y[31];
        xm = xn ? (32'h0000_0000 - x) : x;
        ym = yn ? (32'h0000_0000 - y) : y;
        ym = (ym == 32'h0000_0000) ? 32'h0000_0001 : ym;
        q  = xm / ym;
        r  = xm % ym;
        q  = (xn ^ yn) ? (32'h0000_0000 - q) : q;
        r  = xn ? (32'h0000_0000 - r) : r;
        return {r, q};
    endfunction

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      a_q, a_d;
    logic [31:0]      b_q, b_d;
    logic [31:0]      hi_q, hi_d;
    logic [31:0]      lo_q, lo_d;

    logic             is_mul_s;
    logic             div_zero_s;
    logic [63:0]      res_s;
    logic             md_start_s;
    logic             mt_op_s;

    assign is_mul_s   = (op_q == OP_MULT) || (op_q == OP_MULTU);
    assign div_zero_s = !is_mul_s && (b_q == 32'h0000_0000);
    assign res_s      = is_mul_s ? mul64(a_q, b_q, op_q == OP_MULT)
                                 : div64(a_q, b_q, op_q == OP_DIV);

    assign md_start_s = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    assign mt_op_s    = (op == OP_MTHI) || (op == OP_MTLO);

    assign busy      = (state_q == S_RUN);
    assign stall_req = busy | md_start_s | (busy & mt_op_s);
    assign hi        = hi_q;
    assign lo        = lo_q;

    // Next-state logic: start/MT* in IDLE, countdown and write-back in RUN; ops ignored while busy.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            S_IDLE: begin
                case (op)
                    OP_MULT, OP_MULTU: begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(MULT_CYCLES);
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end
                    OP_DIV, OP_DIVU: begin
                        state_d = S_RUN;
                        cnt_d   = CNT_W'(DIV_CYCLES);
                        op_d    = op;
                        a_d     = a;
                        b_d     = b;
                    end
                    OP_MTHI: hi_d = a;
                    OP_MTLO: lo_d = a;
                    default: begin
                        state_d = S_IDLE;
                    end
                endcase
            end
            S_RUN: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    if (!div_zero_s) begin
                        hi_d = res_s[63:32];
                        lo_d = res_s[31:0];
                    end else begin
                        hi_d = hi_q;
                        lo_d = lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers; reset aborts any running operation without writing HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 3'd0;
            a_q     <= 32'h0000_0000;
            b_q     <= 32'h0000_0000;
            hi_q    <= 32'h0000_0000;
            lo_q    <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: cycle-by-cycle reference model plus directed literal expectations.
module tb_md_unit;
    localparam int MULT_CYCLES = 5;
    localparam int DIV_CYCLES  = 10;

    logic        clk   = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  op    = 3'd0;
    logic [31:0] a     = 32'h0;
    logic [31:0] b     = 32'h0;
    logic        busy;
    logic        stall_req;
    logic [31:0] hi;
    logic [31:0] lo;

    int checks = 0;
    int errors = 0;

    md_unit #(.MULT_CYCLES(MULT_CYCLES), .DIV_CYCLES(DIV_CYCLES)) dut (
        .clk(clk), .reset(reset), .op(op), .a(a), .b(b),
        .busy(busy), .stall_req(stall_req), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: remaining busy cycles and a pending result computed at start.
    int          m_rem   = 0;
    bit          m_valid = 1'b0;
    bit          p_wr    = 1'b0;
    logic [31:0] m_hi    = 32'h0;
    logic [31:0] m_lo    = 32'h0;
    logic [31:0] p_hi    = 32'h0;
    logic [31:0] p_lo    = 32'h0;

    always @(posedge clk) begin
        longint          sa, sb, sq, sr;
        longint unsigned ua, ub, up;
        sa = longint'(signed'(a));
        sb = longint'(signed'(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        if (reset) begin
            m_valid = 1'b1; m_rem = 0; m_hi = 32'h0; m_lo = 32'h0; p_wr = 1'b0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0 && p_wr) begin m_hi = p_hi; m_lo = p_lo; end
        end else begin
            case (op)
                3'd1: begin sq = sa * sb; {p_hi, p_lo} = sq; p_wr = 1'b1; m_rem = MULT_CYCLES; end
                3'd2: begin up = ua * ub; {p_hi, p_lo} = up; p_wr = 1'b1; m_rem = MULT_CYCLES; end
                3'd3: begin
                    p_wr = (b != 32'h0);
                    if (p_wr) begin sq = sa / sb; sr = sa % sb; p_lo = sq[31:0]; p_hi = sr[31:0]; end
                    m_rem = DIV_CYCLES;
                end
                3'd4: begin
                    p_wr = (b != 32'h0);
                    if (p_wr) begin up = ua / ub; p_lo = up[31:0]; up = ua % ub; p_hi = up[31:0]; end
                    m_rem = DIV_CYCLES;
                end
                3'd5: m_hi = a;
                3'd6: m_lo = a;
                default: ;
            endcase
        end
    end

    // Compare every cycle, away from the active edge.
    always @(negedge clk) begin
        if (m_valid) begin
            check("busy", {31'd0, busy}, {31'd0, m_rem > 0});
            check("stall_req", {31'd0, stall_req},
                  {31'd0, (m_rem > 0) || (op inside {3'd1, 3'd2, 3'd3, 3'd4})});
            check("hi", hi, m_hi);
            check("lo", lo, m_lo);
        end
    end

    task automatic cyc(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op = o; a = x; b = y;
        @(posedge clk);
        #1;
    endtask

    task automatic run_op(input string nm, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                          input int exp_n, input logic [31:0] eh, input logic [31:0] el);
        int n;
        n = 0;
        cyc(o, x, y);
        while (busy === 1'b1 && n < 50) begin
            n++;
            cyc(3'd0, 32'h0, 32'h0);
        end
        check({nm, "_cycles"}, 32'(n), 32'(exp_n));
        check({nm, "_hi"}, hi, eh);
        check({nm, "_lo"}, lo, el);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        cyc(3'd0, 32'h0, 32'h0);
        cyc(3'd0, 32'h0, 32'h0);
        reset = 1'b0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);

        run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_op("multu", 3'd2, 32'hFFFF_FFFE, 32'd3, 5, 32'h0000_0002, 32'hFFFF_FFFA);
        run_op("mult_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 5, 32'h4000_0000, 32'h0000_0000);
        run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_negdivisor", 3'd3, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("divu", 3'd4, 32'd7, 32'd2, 10, 32'h0000_0001, 32'h0000_0003);

        cyc(3'd5, 32'h11, 32'h0);
        cyc(3'd6, 32'h22, 32'h0);
        check("mthi", hi, 32'h11);
        check("mtlo", lo, 32'h22);
        run_op("div_zero", 3'd3, 32'd5, 32'd0, 10, 32'h11, 32'h22);
        run_op("divu_zero", 3'd4, 32'd9, 32'd0, 10, 32'h11, 32'h22);
        run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0, 32'h8000_0000);

        // Ops presented while busy must be ignored, including on the completion edge.
        cyc(3'd1, 32'd3, 32'd4);
        cyc(3'd4, 32'd100, 32'd9);
        cyc(3'd6, 32'hDEAD, 32'd1);
        cyc(3'd5, 32'hBEEF, 32'd2);
        cyc(3'd1, 32'd7, 32'd7);
        cyc(3'd4, 32'd50, 32'd7);
        check("b2b_busy", {31'd0, busy}, 32'd0);
        check("b2b_hi", hi, 32'h0);
        check("b2b_lo", lo, 32'd12);
        run_op("b2b_divu", 3'd4, 32'd100, 32'd9, 10, 32'd1, 32'd11);

        cyc(3'd3, 32'd100, 32'd7);
        cyc(3'd0, 32'h0, 32'h0);
        cyc(3'd0, 32'h0, 32'h0);
        cyc(3'd0, 32'h0, 32'h0);
        reset = 1'b1;
        cyc(3'd0, 32'h0, 32'h0);
        reset = 1'b0;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_hi", hi, 32'h0);
        check("midrst_lo", lo, 32'h0);
        repeat (12) cyc(3'd0, 32'h0, 32'h0);
        check("nolate_hi", hi, 32'h0);
        check("nolate_lo", lo, 32'h0);

        op = 3'd1; a = 32'd9; b = 32'd9;
        #1;
        check("stall_mult_idle", {31'd0, stall_req}, 32'd1);
        op = 3'd5; a = 32'h1234;
        #1;
        check("stall_mthi_idle", {31'd0, stall_req}, 32'd0);
        cyc(3'd5, 32'h1234, 32'h0);
        check("mthi_idle_hi", hi, 32'h1234);
        cyc(3'd2, 32'd2, 32'd2);
        op = 3'd5; a = 32'h5555;
        #1;
        check("stall_mthi_busy", {31'd0, stall_req}, 32'd1);
        cyc(3'd5, 32'h5555, 32'h0);
        check("mthi_busy_hi", hi, 32'h1234);
        n = 1;
        while (busy === 1'b1 && n < 50) begin
            n++;
            cyc(3'd0, 32'h0, 32'h0);
        end
        check("multu_small_cycles", 32'(n), 32'd5);
        check("multu_small_hi", hi, 32'h0);
        check("multu_small_lo", lo, 32'd4);
        cyc(3'd7, 32'hAAAA, 32'hBBBB);
        check("reserved_busy", {31'd0, busy}, 32'd0);
        check("reserved_lo", lo, 32'd4);
        cyc(3'd0, 32'h0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion before 100000");
        $fatal(1);
    end
endmodule
